// File: rtl/mult_pkg.sv
// Shared types and constants for the 16x16 shift-add multiplier controller.
package mult_pkg;

  localparam int unsigned WIDTH_M = 16;
  localparam int unsigned WIDTH_C = 4;
  localparam int unsigned WIDTH_P = 2 * WIDTH_M;

  // Value of the iteration counter on the final CALC cycle.
  localparam logic [WIDTH_C-1:0] ITER_LAST = WIDTH_C'(WIDTH_M - 1);

  // Sequencer states. The values are explicit so the legacy encoding is kept.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_iter_shadow.sv
// Shadow iteration counter. It tracks the CALC cycles independently of the
// datapath counter and raises a sticky error whenever the datapath's
// last-iteration flag disagrees with the shadow count.
module mult_iter_shadow #(
  parameter int unsigned WIDTH_M = mult_pkg::WIDTH_M,
  parameter int unsigned WIDTH_C = mult_pkg::WIDTH_C
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic step_i,
  input  logic count_check_i,
  output logic err_o
);

  localparam logic [WIDTH_C-1:0] LAST = WIDTH_C'(WIDTH_M - 1);

  logic [WIDTH_C-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;

  // Next-state logic: clear on accept, count and compare on every CALC cycle.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + WIDTH_C'(1);
      if (count_check_i != (cnt_q == LAST)) begin
        err_d = 1'b1;
      end
    end
  end

  // State registers. The error flag is cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/mult_controller.sv
// FSM sequencer for the 16x16 shift-add multiplier datapath.
// It accepts a request on src_valid/src_ready, strobes load_words + flush,
// then issues one add_shift or shift per multiplier bit, and finally holds
// dest_valid until dest_ready.
// Optional build macro MULT_ZERO_SKIP_EN: a zero operand skips CALC and goes
// straight to DONE.
module mult_controller
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH_M = mult_pkg::WIDTH_M,
  parameter int unsigned WIDTH_C = mult_pkg::WIDTH_C
) (
  input  logic clk,
  input  logic reset,
  input  logic src_valid,
  output logic src_ready,
  output logic dest_valid,
  input  logic dest_ready,
  input  logic multiplier_lsb,
  input  logic count_check,
  input  logic empty,
  output logic load_words,
  output logic flush,
  output logic add_shift,
  output logic shift,
  output logic busy,
  output logic err
);

  mult_state_e state_q, state_d;
  logic        accept;
  logic        in_calc;

  assign accept  = (state_q == IDLE) && src_valid;
  assign in_calc = (state_q == CALC);

`ifndef MULT_ZERO_SKIP_EN
  logic unused_empty;
  assign unused_empty = empty;
`endif

  // Next state and Mealy datapath strobes.
  always_comb begin
    state_d    = state_q;
    load_words = 1'b0;
    flush      = 1'b0;
    add_shift  = 1'b0;
    shift      = 1'b0;
    case (state_q)
      IDLE: begin
        if (src_valid) begin
          load_words = 1'b1;
          flush      = 1'b1;
`ifdef MULT_ZERO_SKIP_EN
          state_d    = empty ? DONE : CALC;
`else
          state_d    = CALC;
`endif
        end
      end
      CALC: begin
        add_shift = multiplier_lsb;
        shift     = !multiplier_lsb;
        if (count_check) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (dest_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign src_ready  = (state_q == IDLE);
  assign dest_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);

  mult_iter_shadow #(
    .WIDTH_M(WIDTH_M),
    .WIDTH_C(WIDTH_C)
  ) u_shadow (
    .clk          (clk),
    .reset        (reset),
    .start_i      (accept),
    .step_i       (in_calc),
    .count_check_i(count_check),
    .err_o        (err)
  );

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller together with a behavioural shift-add datapath.
module tb_mult_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic src_valid, src_ready, dest_valid, dest_ready;
  logic multiplier_lsb, count_check, empty;
  logic load_words, flush, add_shift, shift, busy, err;

  logic [15:0] op_a, op_b;
  logic        cc_inj;

  logic [15:0] mcand_q, mplier_q;
  logic [31:0] prod_q;
  logic [3:0]  dcnt_q;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mult_controller #(
    .WIDTH_M(16),
    .WIDTH_C(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .dest_valid    (dest_valid),
    .dest_ready    (dest_ready),
    .multiplier_lsb(multiplier_lsb),
    .count_check   (count_check),
    .empty         (empty),
    .load_words    (load_words),
    .flush         (flush),
    .add_shift     (add_shift),
    .shift         (shift),
    .busy          (busy),
    .err           (err)
  );

  // Datapath: the counter has no clear and wraps after 16 iterations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      if (load_words) begin
        mcand_q  <= op_a;
        mplier_q <= op_b;
      end
      if (flush) prod_q <= '0;
      if (add_shift) prod_q <= prod_q + ({16'h0, mcand_q} << dcnt_q);
      if (add_shift || shift) begin
        mplier_q <= mplier_q >> 1;
        dcnt_q   <= dcnt_q + 4'd1;
      end
    end
  end

  assign multiplier_lsb = mplier_q[0];
  assign count_check    = (dcnt_q == 4'd15) ^ cc_inj;
  assign empty          = (op_a == 16'h0) || (op_b == 16'h0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    int unsigned adds;
    bit          zero;
    int unsigned hold;
  } vec_t;

  vec_t vecs[8];

  task automatic run_mult(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] prod, input int unsigned adds,
                          input bit zero, input int unsigned hold);
    int unsigned lat, nadd, bad, exp_lat, exp_adds;
    logic [31:0] held;
    exp_lat  = 16;
    exp_adds = adds;
`ifdef MULT_ZERO_SKIP_EN
    if (zero) begin
      exp_lat  = 0;
      exp_adds = 0;
    end
`else
    if (zero) exp_lat = 16;
`endif
    op_a = a; op_b = b; src_valid = 1'b1; dest_ready = (hold == 0); #1;
    chk({nm, " accept"}, {27'h0, src_ready, load_words, flush, add_shift, shift}, 32'b11100);
    @(posedge clk); #1;
    src_valid = 1'b0;
    lat = 0; nadd = 0; bad = 0;
    while (!dest_valid && lat < 40) begin
      if (load_words || flush || !(add_shift ^ shift) || src_ready) bad++;
      if (add_shift) nadd++;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " adds"}, 32'(nadd), 32'(exp_adds));
    chk({nm, " calc strobes"}, 32'(bad), 32'd0);
    chk({nm, " product"}, prod_q, prod);
    chk({nm, " err"}, {31'h0, err}, 32'd0);
    dest_ready = 1'b0; src_valid = 1'b1; op_a = 16'h5555; op_b = 16'h0003;
    held = prod_q; bad = 0;
    for (int unsigned i = 0; i < hold; i++) begin
      #1;
      if (!dest_valid || src_ready || load_words || flush || add_shift || shift ||
          !busy || prod_q !== held) bad++;
      @(posedge clk); #1;
    end
    if (!dest_valid || prod_q !== held) bad++;
    chk({nm, " done hold"}, 32'(bad), 32'd0);
    src_valid = 1'b0; dest_ready = 1'b1;
    @(posedge clk); #1;
    dest_ready = 1'b0;
    chk({nm, " back to idle"}, {29'h0, busy, dest_valid, src_ready}, 32'b001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned edges, bad;
    src_valid = 1'b0; dest_ready = 1'b0; op_a = '0; op_b = '0; cc_inj = 1'b0;

    vecs[0] = '{"3x5",       16'd3,     16'd5,     32'd15,         2,  1'b0, 0};
    vecs[1] = '{"ffffxffff", 16'hFFFF,  16'hFFFF,  32'hFFFE0001,   16, 1'b0, 0};
    vecs[2] = '{"0x1234",    16'h0,     16'h1234,  32'h0,          5,  1'b1, 0};
    vecs[3] = '{"1234x0",    16'h1234,  16'h0,     32'h0,          0,  1'b1, 2};
    vecs[4] = '{"abcdx1",    16'hABCD,  16'h1,     32'h0000ABCD,   1,  1'b0, 5};
    vecs[5] = '{"8000x8000", 16'h8000,  16'h8000,  32'h40000000,   1,  1'b0, 0};
    vecs[6] = '{"7x9",       16'd7,     16'd9,     32'd63,         2,  1'b0, 1};
    vecs[7] = '{"1x0101",    16'h0001,  16'h0101,  32'h00000101,   2,  1'b0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {25'h0, dest_valid, busy, err, load_words, flush, add_shift, shift}, 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("post reset", {29'h0, src_ready, busy, dest_valid}, 32'b100);

    foreach (vecs[i]) begin
      run_mult(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].adds,
               vecs[i].zero, vecs[i].hold);
    end

    // Reset in the middle of CALC aborts with no response.
    op_a = 16'h1111; op_b = 16'h00FF; src_valid = 1'b1; dest_ready = 1'b1; #1;
    @(posedge clk); #1;
    src_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midop busy", {31'h0, busy}, 32'd1);
    reset = 1'b0; #1;
    chk("midop reset outputs", {25'h0, busy, dest_valid, load_words, flush, add_shift, shift, err}, 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("midop idle", {30'h0, src_ready, busy}, 32'b10);
    run_mult("rst 7x9", 16'd7, 16'd9, 32'd63, 2, 1'b0, 0);

    // Back-to-back: second request waits on the bus until the first completes.
    op_a = 16'd2; op_b = 16'd3; src_valid = 1'b1; dest_ready = 1'b1; #1;
    @(posedge clk); #1;
    op_a = 16'd4; op_b = 16'd5;
    edges = 0; bad = 0;
    while (!dest_valid && edges < 40) begin
      if (load_words || src_ready) bad++;
      @(posedge clk); #1;
      edges++;
    end
    chk("b2b first latency", 32'(edges), 32'd16);
    chk("b2b first product", prod_q, 32'd6);
    chk("b2b ignored src", 32'(bad) + {31'h0, load_words}, 32'd0);
    @(posedge clk); #1;
    chk("b2b second accept", {30'h0, src_ready, load_words}, 32'b11);
    @(posedge clk); #1;
    src_valid = 1'b0;
    edges = 0;
    while (!dest_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("b2b second latency", 32'(edges), 32'd16);
    chk("b2b second product", prod_q, 32'd20);
    @(posedge clk); #1;
    dest_ready = 1'b0;
    chk("b2b idle", {31'h0, busy}, 32'd0);

    // A premature count_check ends CALC and latches err until reset.
    op_a = 16'd3; op_b = 16'd5; src_valid = 1'b1; #1;
    @(posedge clk); #1;
    src_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cc_inj = 1'b1; #1;
    chk("err before edge", {31'h0, err}, 32'd0);
    @(posedge clk); #1;
    cc_inj = 1'b0;
    chk("err set, done", {30'h0, dest_valid, err}, 32'b11);
    dest_ready = 1'b1;
    @(posedge clk); #1;
    dest_ready = 1'b0;
    chk("err sticky", {30'h0, busy, err}, 32'b01);
    reset = 1'b0; #1;
    chk("err cleared", {31'h0, err}, 32'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    run_mult("post err 3x5", 16'd3, 16'd5, 32'd15, 2, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
